// File: rtl/rf_wb_scheduler.sv
// ---------------------------------------------------------------------------
// rf_wb_scheduler
//
// Shares the single register-file write port between the in-order pipeline
// writeback and a long-latency unit (divider / load miss). The pipeline
// normally wins the port. A starvation guard forces the long-latency result
// through after it has been blocked for STARVE_LIMIT consecutive cycles.
//
// The block also keeps a scoreboard of registers that have a long-latency
// result outstanding. It stalls decode on any RAW or WAW hit against that
// scoreboard.
//
// Parameters
//   STARVE_LIMIT   consecutive blocked cycles tolerated for the lu result (>=1)
//
// Ports
//   clk, reset                      clock (rising edge), async active-high reset
//   wb_valid/addr/data, wb_ready    pipeline writeback request / acceptance
//   lu_issue_valid/addr             long-latency issue; marks destination pending
//   lu_valid/addr/data, lu_ready    long-latency result request / acceptance
//   dec_rs1/rs2/rd, dec_stall       decode operands and hazard stall
//   rf_we/waddr/wdata               register file write port
//   pending                         scoreboard bitmap (bit 0 always 0)
// ---------------------------------------------------------------------------
module rf_wb_scheduler #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        wb_valid,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        wb_ready,

    input  logic        lu_issue_valid,
    input  logic [4:0]  lu_issue_addr,

    input  logic        lu_valid,
    input  logic [4:0]  lu_addr,
    input  logic [31:0] lu_data,
    output logic        lu_ready,

    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic [4:0]  dec_rd,
    output logic        dec_stall,

    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,

    output logic [31:0] pending
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_FORCE_AT = CNT_W'(STARVE_LIMIT - 1);

    typedef enum logic {
        ARB   = 1'b0,
        FORCE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       pending_q, pending_d;

    logic              wb_acc;
    logic              lu_acc;
    logic              lu_blocked;
    logic [4:0]        sel_addr;
    logic [31:0]       sel_data;

    // Handshake: the pipeline owns the port in ARB. In FORCE the pipeline
    // is held off and the long-latency result goes through unconditionally.
    always_comb begin
        wb_ready = 1'b0;
        lu_ready = 1'b0;
        case (state_q)
            ARB: begin
                wb_ready = 1'b1;
                lu_ready = lu_valid & ~wb_valid;
            end
            FORCE: begin
                wb_ready = 1'b0;
                lu_ready = lu_valid;
            end
            default: begin
                wb_ready = 1'b0;
                lu_ready = 1'b0;
            end
        endcase
    end

    assign wb_acc     = wb_valid & wb_ready;
    assign lu_acc     = lu_valid & lu_ready;
    assign lu_blocked = lu_valid & ~lu_ready;

    // Write-port mux. The write enable is suppressed for x0, but the
    // request is still acknowledged so the producer can move on.
    always_comb begin
        sel_addr = lu_addr;
        sel_data = lu_data;
        if (wb_acc) begin
            sel_addr = wb_addr;
            sel_data = wb_data;
        end
    end

    assign rf_we    = (wb_acc | lu_acc) & (sel_addr != 5'd0);
    assign rf_waddr = sel_addr;
    assign rf_wdata = sel_data;

    // Starvation counter and arbitration state. The counter only runs while
    // the lu result is waiting. Any acceptance or drop of lu_valid clears it.
    // FORCE always lasts one cycle: it either accepts the pending result or
    // sees lu_valid gone, and both cases return to ARB.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        if (lu_blocked) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        case (state_q)
            ARB: begin
                if (lu_blocked && (cnt_q == CNT_FORCE_AT)) begin
                    state_d = FORCE;
                end
            end
            FORCE: begin
                if (lu_acc || !lu_valid) begin
                    state_d = ARB;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ARB;
                cnt_d   = '0;
            end
        endcase
    end

    // Scoreboard update. The set is applied after the clear, so a new issue
    // to a register wins over a completion to that register in the same
    // cycle. Bit 0 is kept clear because x0 never holds a result.
    always_comb begin
        pending_d = pending_q;
        if (lu_acc) begin
            pending_d[lu_addr] = 1'b0;
        end
        if (lu_issue_valid && (lu_issue_addr != 5'd0)) begin
            pending_d[lu_issue_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ARB;
            cnt_q     <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    // Decode stall looks only at the registered bitmap. A consumer of a
    // completing register stalls through the acceptance cycle, then reads the
    // freshly written value from the register file.
    assign dec_stall = ((dec_rs1 != 5'd0) & pending_q[dec_rs1]) |
                       ((dec_rs2 != 5'd0) & pending_q[dec_rs2]) |
                       ((dec_rd  != 5'd0) & pending_q[dec_rd]);

    assign pending = pending_q;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// ---------------------------------------------------------------------------
// tb_rf_wb_scheduler
//
// Testbench for rf_wb_scheduler with STARVE_LIMIT = 4. Each expected register
// file write is queued when the stimulus that causes it is driven. A negedge
// monitor pops the queue on every rf_we and compares the address and data.
// Handshake, scoreboard and stall outputs are compared directly against
// values the bench works out for each cycle.
// ---------------------------------------------------------------------------
module tb_rf_wb_scheduler;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_ready;
    logic        lu_issue_valid;
    logic [4:0]  lu_issue_addr;
    logic        lu_valid;
    logic [4:0]  lu_addr;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic        dec_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pending;

    int checks   = 0;
    int failures = 0;
    wr_t expQ[$];

    rf_wb_scheduler #(.STARVE_LIMIT(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .wb_valid       (wb_valid),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .wb_ready       (wb_ready),
        .lu_issue_valid (lu_issue_valid),
        .lu_issue_addr  (lu_issue_addr),
        .lu_valid       (lu_valid),
        .lu_addr        (lu_addr),
        .lu_data        (lu_data),
        .lu_ready       (lu_ready),
        .dec_rs1        (dec_rs1),
        .dec_rs2        (dec_rs2),
        .dec_rd         (dec_rd),
        .dec_stall      (dec_stall),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .pending        (pending)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Moves to just after the next rising edge, where inputs are changed.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic lv, input logic [4:0] la, input logic [31:0] ld);
        wb_valid = wv;
        wb_addr  = wa;
        wb_data  = wd;
        lu_valid = lv;
        lu_addr  = la;
        lu_data  = ld;
    endtask

    task automatic expectWrite(input logic [4:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        expQ.push_back(w);
    endtask

    // Write monitor: every rf_we must match the oldest queued write.
    always @(negedge clk) begin
        if (rf_we) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedWrite", 32'(rf_we), 32'h0);
            end else begin
                wr_t w;
                w = expQ.pop_front();
                checkOutput("wrAddr", 32'(rf_waddr), 32'(w.addr));
                checkOutput("wrData", rf_wdata, w.data);
            end
        end
    end

    initial begin
        reset          = 1'b1;
        lu_issue_valid = 1'b0;
        lu_issue_addr  = 5'd0;
        dec_rs1        = 5'd0;
        dec_rs2        = 5'd0;
        dec_rd         = 5'd0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Reset, idle inputs
        @(negedge clk);
        checkOutput("rstWbReady", 32'(wb_ready), 32'h1);
        checkOutput("rstLuReady", 32'(lu_ready), 32'h0);
        checkOutput("rstRfWe", 32'(rf_we), 32'h0);
        checkOutput("rstStall", 32'(dec_stall), 32'h0);
        checkOutput("rstPending", pending, 32'h0);
        stepCycle();
        reset = 1'b0;

        // Simultaneous wb and lu: the pipeline wins, then lu goes next cycle
        stepCycle();
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd7, 32'h0000_0077);
        expectWrite(5'd5, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("arbRfWe", 32'(rf_we), 32'h1);
        checkOutput("arbWaddr", 32'(rf_waddr), 32'd5);
        checkOutput("arbLuReady", 32'(lu_ready), 32'h0);
        stepCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h0000_0077);
        expectWrite(5'd7, 32'h0000_0077);
        @(negedge clk);
        checkOutput("luAfterLuReady", 32'(lu_ready), 32'h1);
        checkOutput("luAfterWaddr", 32'(rf_waddr), 32'd7);
        stepCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Starvation: wb held every cycle, lu forced through on cycle 4
        stepCycle();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 5'd10, 32'h100 + 32'(i), 1'b1, 5'd12, 32'h0000_CAFE);
            expectWrite(5'd10, 32'h100 + 32'(i));
            @(negedge clk);
            checkOutput($sformatf("starveLuReady%0d", i), 32'(lu_ready), 32'h0);
            checkOutput($sformatf("starveWbReady%0d", i), 32'(wb_ready), 32'h1);
            stepCycle();
        end
        applyStimulus(1'b1, 5'd10, 32'h104, 1'b1, 5'd12, 32'h0000_CAFE);
        expectWrite(5'd12, 32'h0000_CAFE);
        @(negedge clk);
        checkOutput("forceWbReady", 32'(wb_ready), 32'h0);
        checkOutput("forceLuReady", 32'(lu_ready), 32'h1);
        checkOutput("forceWaddr", 32'(rf_waddr), 32'd12);
        stepCycle();
        applyStimulus(1'b1, 5'd10, 32'h104, 1'b0, 5'd0, 32'h0);
        expectWrite(5'd10, 32'h104);
        @(negedge clk);
        checkOutput("afterForceWbReady", 32'(wb_ready), 32'h1);
        stepCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Scoreboard RAW/WAW on x9
        lu_issue_valid = 1'b1;
        lu_issue_addr  = 5'd9;
        dec_rs2        = 5'd9;
        @(negedge clk);
        checkOutput("issueCycleStall", 32'(dec_stall), 32'h0);
        stepCycle();
        lu_issue_valid = 1'b0;
        @(negedge clk);
        checkOutput("pend9", pending, 32'h0000_0200);
        checkOutput("rs2Stall", 32'(dec_stall), 32'h1);
        stepCycle();
        dec_rs2 = 5'd0;
        dec_rd  = 5'd9;
        @(negedge clk);
        checkOutput("rdStall", 32'(dec_stall), 32'h1);
        stepCycle();
        dec_rd  = 5'd0;
        dec_rs1 = 5'd9;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h0000_0099);
        expectWrite(5'd9, 32'h0000_0099);
        @(negedge clk);
        checkOutput("accLuReady", 32'(lu_ready), 32'h1);
        checkOutput("accCycleStall", 32'(dec_stall), 32'h1);
        stepCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        checkOutput("postAccStall", 32'(dec_stall), 32'h0);
        checkOutput("postAccPending", pending, 32'h0);
        stepCycle();
        dec_rs1 = 5'd0;

        // Same-cycle issue and acceptance on x3: set wins
        lu_issue_valid = 1'b1;
        lu_issue_addr  = 5'd3;
        stepCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h0000_0033);
        expectWrite(5'd3, 32'h0000_0033);
        stepCycle();
        lu_issue_valid = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        checkOutput("setWinsPending", pending, 32'h0000_0008);
        stepCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h0000_0333);
        expectWrite(5'd3, 32'h0000_0333);
        stepCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        lu_issue_valid = 1'b1;
        lu_issue_addr  = 5'd0;
        @(negedge clk);
        checkOutput("clear3Pending", pending, 32'h0);
        stepCycle();
        lu_issue_valid = 1'b0;
        @(negedge clk);
        checkOutput("issueX0Pending", pending, 32'h0);

        // Writeback to x0 is accepted but not written
        stepCycle();
        applyStimulus(1'b1, 5'd0, 32'h1, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        checkOutput("x0WbReady", 32'(wb_ready), 32'h1);
        checkOutput("x0RfWe", 32'(rf_we), 32'h0);
        stepCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Async reset while in FORCE with x10 pending
        lu_issue_valid = 1'b1;
        lu_issue_addr  = 5'd10;
        stepCycle();
        lu_issue_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 5'd1, 32'h200 + 32'(i), 1'b1, 5'd10, 32'h0000_00AA);
            expectWrite(5'd1, 32'h200 + 32'(i));
            stepCycle();
        end
        applyStimulus(1'b1, 5'd1, 32'h203, 1'b1, 5'd10, 32'h0000_00AA);
        #1;
        checkOutput("preRstForce", 32'(wb_ready), 32'h0);
        checkOutput("preRstPending", pending, 32'h0000_0400);
        reset = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("asyncRstWbReady", 32'(wb_ready), 32'h1);
        checkOutput("asyncRstLuReady", 32'(lu_ready), 32'h0);
        checkOutput("asyncRstPending", pending, 32'h0);
        checkOutput("asyncRstRfWe", 32'(rf_we), 32'h0);
        stepCycle();
        reset = 1'b0;
        stepCycle();
        @(negedge clk);

        checkOutput("expQueueDrained", 32'(expQ.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rf_wb_scheduler.md
# rf_wb_scheduler

Write-port scheduler and pending-register scoreboard for the pipeline's 32x32 register file (x0 hardwired zero, one synchronous write port, two combinational read ports). It shares the single write port between the in-order pipeline writeback and a long-latency unit (divider/load miss), with a starvation guard. It also tracks registers whose long-latency result is outstanding and raises decode stalls on RAW/WAW hazards. Sits between the WB stage, the long-latency unit and the register file write port; decode consumes its stall outputs.

## Interface
- STARVE_LIMIT, 4: consecutive cycles the long-latency completion may be blocked before it is forced onto the port (>=1)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- wb_valid  in  1  pipeline writeback request
- wb_addr  in  5  pipeline destination register
- wb_data  in  32  pipeline writeback data
- wb_ready  out  1  pipeline writeback accepted this cycle
- lu_issue_valid  in  1  long-latency op issued this cycle (marks destination pending)
- lu_issue_addr  in  5  its destination register
- lu_valid  in  1  long-latency result available; held until accepted
- lu_addr  in  5  result destination
- lu_data  in  32  result data
- lu_ready  out  1  long-latency result accepted this cycle
- dec_rs1, dec_rs2, dec_rd  in  5 each  decode-stage source/destination registers
- dec_stall  out  1  decode must hold
- rf_we  out  1  register file write enable
- rf_waddr  out  5  register file write address
- rf_wdata  out  32  register file write data
- pending  out  32  scoreboard bitmap; bit 0 always 0

## Operation
- FSM states: ARB, FORCE. Counter cnt, width $clog2(STARVE_LIMIT+1).
- ARB: wb_ready = 1; lu_ready = lu_valid & ~wb_valid. Pipeline wins the port.
- FORCE: wb_ready = 0; lu_ready = lu_valid. Pipeline must hold its WB values.
- Port mux: an accepted wb drives rf_waddr/rf_wdata from wb_*, otherwise an accepted lu drives them from lu_*. rf_we = (wb_valid & wb_ready) | (lu_valid & lu_ready), forced 0 when the selected address is 0. A write to x0 is still accepted (ready asserted).
- cnt: increments on each cycle with lu_valid & ~lu_ready. Clears on lu acceptance or when lu_valid is low.
- ARB->FORCE when lu is blocked in the current cycle and cnt == STARVE_LIMIT-1.
- FORCE->ARB on lu acceptance, or if lu_valid drops. Dropping lu_valid is a protocol violation, but the return is still required. cnt clears on either exit.
- Scoreboard:
  - pending[lu_issue_addr] sets on lu_issue_valid when lu_issue_addr != 0.
  - pending[lu_addr] clears on lu acceptance.
  - Set and clear of the same register in the same cycle: set wins.
- dec_stall = (rs1!=0 & pending[rs1]) | (rs2!=0 & pending[rs2]) | (rd!=0 & pending[rd]). This is purely combinational from the current bitmap, with no same-cycle bypass of a clear.
- The unit never issues to a pending register, because decode stalls on the dec_rd hit.

## Timing
- Reset asserted (asynchronous): state ARB, cnt 0, pending 0. With idle inputs: wb_ready 1, lu_ready 0, rf_we 0, dec_stall 0. Reset mid-FORCE returns to ARB immediately. Outstanding pending bits are lost, and the unit is reset alongside.
- All handshake and port outputs are combinational from inputs and state. The RF write occurs at the clock edge ending the acceptance cycle, so there is zero added latency.
- A scoreboard change is visible on pending/dec_stall the cycle after the edge. A dependent decode stalls through the lu acceptance cycle and proceeds the next cycle, reading the new value from the RF.
- Worst-case lu wait under continuous wb traffic: STARVE_LIMIT cycles blocked, then accepted on cycle STARVE_LIMIT+1.

## Test plan
- Reset, idle inputs -> wb_ready=1, lu_ready=0, rf_we=0, pending=0.
- wb_valid=1, addr 5, data 0xDEADBEEF; lu_valid=1, addr 7 in the same cycle -> rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, lu_ready=0. Next cycle wb_valid=0 -> lu_ready=1, rf_waddr=7.
- STARVE_LIMIT=4, wb_valid held 1, lu_valid from cycle 0 -> lu_ready=0 cycles 0-3. Cycle 4: wb_ready=0, lu_ready=1, rf_waddr=lu_addr. Cycle 5: back to ARB, wb_ready=1.
- Issue to x9, then dec_rs2=9 -> pending[9]=1 and dec_stall=1 until the cycle after lu acceptance for x9; dec_rd=9 also stalls.
- Same-cycle issue to x3 and lu acceptance for x3 -> pending[3] remains 1. Issue to x0 -> pending stays 0.
- wb to x0 with data 0x1 -> wb_ready=1, rf_we=0. Assert reset while in FORCE with pending=0x0000_0400 -> ARB, pending=0 without waiting for a clock edge.
